// File: rtl/rocc_multi_accumulator.sv
// RoCC accelerator with NUM_ACC accumulators selected by rs2: write, read, add and
// memory load-add, with one command in flight at a time.
module rocc_multi_accumulator #(
    parameter int XLEN      = 64,
    parameter int NUM_ACC   = 4,
    parameter int ADDR_BITS = 40,
    parameter int TAG_BITS  = 7,
    parameter int MEM_TAG   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [6:0]           cmd_funct,
    input  logic [4:0]           cmd_rd,
    input  logic                 cmd_xd,
    input  logic [XLEN-1:0]      cmd_rs1,
    input  logic [XLEN-1:0]      cmd_rs2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [4:0]           resp_rd,
    output logic [XLEN-1:0]      resp_data,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    output logic [4:0]           mem_req_cmd,
    output logic [1:0]           mem_req_size,
    input  logic                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]  mem_resp_tag,
    input  logic [XLEN-1:0]      mem_resp_data,
    output logic                 busy,
    output logic                 interrupt
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam logic [TAG_BITS-1:0] REQ_TAG = TAG_BITS'(MEM_TAG);

    localparam logic [6:0] F_WRITE    = 7'd0;
    localparam logic [6:0] F_READ     = 7'd1;
    localparam logic [6:0] F_ADD      = 7'd2;
    localparam logic [6:0] F_LOAD_ADD = 7'd3;

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;

    state_t                 state;
    logic [XLEN-1:0]        acc [NUM_ACC];
    logic [4:0]             rd_q;
    logic                   xd_q;
    logic [IDX_W-1:0]       idx_q;
    logic [ADDR_BITS-1:0]   addr_q;

    logic [IDX_W-1:0]       cmd_idx;
    logic [XLEN-1:0]        add_sum;
    logic [XLEN-1:0]        load_sum;
    logic [XLEN-1:0]        imm_data;
    logic                   mem_hit;
    logic                   unused_rs2_bits;

    assign cmd_idx         = cmd_rs2[IDX_W-1:0];
    assign unused_rs2_bits = ^cmd_rs2[XLEN-1:IDX_W];
    assign add_sum         = acc[cmd_idx] + cmd_rs1;
    assign load_sum        = acc[idx_q] + mem_resp_data;
    assign mem_hit         = mem_resp_valid && (mem_resp_tag == REQ_TAG);

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign mem_req_addr = addr_q;
    assign mem_req_tag  = REQ_TAG;
    assign mem_req_cmd  = 5'd0;
    assign mem_req_size = 2'($clog2(XLEN / 8));

    // WRITE answers with the value being overwritten; illegal functs answer zero.
    always_comb begin
        imm_data = '0;
        case (cmd_funct)
            F_WRITE, F_READ: imm_data = acc[cmd_idx];
            F_ADD:           imm_data = add_sum;
            default:         imm_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            rd_q          <= '0;
            xd_q          <= 1'b0;
            idx_q         <= '0;
            addr_q        <= '0;
            resp_valid    <= 1'b0;
            resp_rd       <= '0;
            resp_data     <= '0;
            mem_req_valid <= 1'b0;
            interrupt     <= 1'b0;
        end else begin
            interrupt <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_q   <= cmd_rd;
                        xd_q   <= cmd_xd;
                        idx_q  <= cmd_idx;
                        addr_q <= cmd_rs1[ADDR_BITS-1:0];
                        if (cmd_funct == F_LOAD_ADD) begin
                            state         <= MEM_REQ;
                            mem_req_valid <= 1'b1;
                        end else begin
                            if (cmd_funct == F_WRITE) acc[cmd_idx] <= cmd_rs1;
                            if (cmd_funct == F_ADD)   acc[cmd_idx] <= add_sum;
                            if (cmd_funct > F_LOAD_ADD) interrupt <= 1'b1;
                            if (cmd_xd) begin
                                state      <= RESP;
                                resp_valid <= 1'b1;
                                resp_rd    <= cmd_rd;
                                resp_data  <= imm_data;
                            end
                        end
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // Responses carrying a foreign tag belong to someone else.
                    if (mem_hit) begin
                        acc[idx_q] <= load_sum;
                        if (xd_q) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rd    <= rd_q;
                            resp_data  <= load_sum;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rocc_multi_accumulator.sv
// Self-checking bench for rocc_multi_accumulator: directed scenarios plus random
// commands compared against an array-based accumulator model.
module tb_rocc_multi_accumulator;

    localparam int XLEN      = 64;
    localparam int NUM_ACC   = 4;
    localparam int ADDR_BITS = 40;
    localparam int TAG_BITS  = 7;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [6:0]           cmd_funct;
    logic [4:0]           cmd_rd;
    logic                 cmd_xd;
    logic [XLEN-1:0]      cmd_rs1;
    logic [XLEN-1:0]      cmd_rs2;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [4:0]           resp_rd;
    logic [XLEN-1:0]      resp_data;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic [4:0]           mem_req_cmd;
    logic [1:0]           mem_req_size;
    logic                 mem_resp_valid;
    logic [TAG_BITS-1:0]  mem_resp_tag;
    logic [XLEN-1:0]      mem_resp_data;
    logic                 busy;
    logic                 interrupt;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] model_acc [NUM_ACC];

    rocc_multi_accumulator #(
        .XLEN(XLEN), .NUM_ACC(NUM_ACC), .ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .MEM_TAG(0)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct), .cmd_rd(cmd_rd),
        .cmd_xd(cmd_xd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_tag(mem_req_tag), .mem_req_cmd(mem_req_cmd), .mem_req_size(mem_req_size),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
        .busy(busy), .interrupt(interrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // A response must never be offered while a new command is being accepted.
    always @(negedge clock) begin
        if (reset === 1'b0) checkOutput("resp_ready_exclusive", 64'(resp_valid && cmd_ready), 64'd0);
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    endtask

    // Present one command for exactly one cycle, then scramble the bus.
    task automatic applyStimulus(input logic [6:0] funct, input logic [4:0] rd, input logic xd,
                                 input logic [63:0] rs1, input logic [63:0] rs2);
        checkOutput("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_funct = funct;
        cmd_rd    = rd;
        cmd_xd    = xd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_funct = 7'($urandom);
        cmd_rd    = 5'($urandom);
        cmd_xd    = 1'($urandom);
        cmd_rs1   = {$urandom, $urandom};
        cmd_rs2   = {$urandom, $urandom};
    endtask

    task automatic runCmd(input logic [6:0] funct, input logic [4:0] rd, input logic xd,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] mem_data,
                          input int req_wait, input int resp_wait);
        int idx;
        logic illegal;
        logic [63:0] exp_data;
        logic [ADDR_BITS-1:0] exp_addr;
        idx      = int'(rs2 % 64'(NUM_ACC));
        illegal  = (funct > 7'd3);
        exp_addr = rs1[ADDR_BITS-1:0];
        exp_data = '0;
        applyStimulus(funct, rd, xd, rs1, rs2);
        checkOutput("interrupt_at_accept_plus1", 64'(interrupt), 64'(illegal));
        if (funct == 7'd3) begin
            checkOutput("load_busy", 64'(busy), 64'd1);
            for (int w = 0; w < req_wait; w++) begin
                checkOutput("mem_req_valid_held", 64'(mem_req_valid), 64'd1);
                checkOutput("mem_req_addr_held", 64'(mem_req_addr), 64'(exp_addr));
                checkOutput("mem_req_size", 64'(mem_req_size), 64'd3);
                checkOutput("mem_req_tag", 64'(mem_req_tag), 64'd0);
                checkOutput("mem_req_cmd", 64'(mem_req_cmd), 64'd0);
                checkOutput("cmd_ready_in_mem_req", 64'(cmd_ready), 64'd0);
                if (w == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_tag   = 7'd0;
                    mem_resp_data  = 64'hDEAD;
                end
                @(negedge clock);
                mem_resp_valid = 1'b0;
            end
            checkOutput("mem_req_valid", 64'(mem_req_valid), 64'd1);
            checkOutput("mem_req_addr", 64'(mem_req_addr), 64'(exp_addr));
            mem_req_ready = 1'b1;
            @(negedge clock);
            mem_req_ready = 1'b0;
            checkOutput("mem_req_dropped", 64'(mem_req_valid), 64'd0);
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 7'd5;
            mem_resp_data  = {$urandom, $urandom};
            @(negedge clock);
            mem_resp_valid = 1'b0;
            checkOutput("foreign_tag_no_resp", 64'(resp_valid), 64'd0);
            checkOutput("foreign_tag_busy", 64'(busy), 64'd1);
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 7'd0;
            mem_resp_data  = mem_data;
            @(negedge clock);
            mem_resp_valid = 1'b0;
            model_acc[idx] = model_acc[idx] + mem_data;
            exp_data       = model_acc[idx];
        end else begin
            case (funct)
                7'd0: begin exp_data = model_acc[idx]; model_acc[idx] = rs1; end
                7'd1: exp_data = model_acc[idx];
                7'd2: begin model_acc[idx] = model_acc[idx] + rs1; exp_data = model_acc[idx]; end
                default: exp_data = '0;
            endcase
        end
        if (xd) begin
            checkOutput("resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("resp_rd", 64'(resp_rd), 64'(rd));
            checkOutput("resp_data", resp_data, exp_data);
            checkOutput("cmd_ready_during_resp", 64'(cmd_ready), 64'd0);
            for (int w = 0; w < resp_wait; w++) begin
                @(negedge clock);
                checkOutput("resp_valid_held", 64'(resp_valid), 64'd1);
                checkOutput("resp_rd_held", 64'(resp_rd), 64'(rd));
                checkOutput("resp_data_held", resp_data, exp_data);
                checkOutput("busy_held", 64'(busy), 64'd1);
            end
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
        end
        checkIdle("after_cmd");
        @(negedge clock);
        checkOutput("interrupt_single_pulse", 64'(interrupt), 64'd0);
    endtask

    initial begin
        logic [6:0]  f;
        logic [63:0] rs1;
        int          kind;

        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_funct      = '0;
        cmd_rd         = '0;
        cmd_xd         = 1'b0;
        cmd_rs1        = '0;
        cmd_rs2        = '0;
        resp_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag   = '0;
        mem_resp_data  = '0;
        for (int i = 0; i < NUM_ACC; i++) model_acc[i] = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkIdle("reset");
        checkOutput("reset_resp_rd", 64'(resp_rd), 64'd0);
        checkOutput("reset_resp_data", resp_data, 64'd0);
        checkOutput("reset_interrupt", 64'(interrupt), 64'd0);

        $display("[TB] write/read idx2");
        runCmd(7'd0, 5'd3, 1'b1, 64'h1234, 64'd2, '0, 0, 0);
        runCmd(7'd1, 5'd4, 1'b1, 64'h0, 64'd2, '0, 0, 0);

        $display("[TB] add wrap idx1 via rs2=0x105");
        runCmd(7'd0, 5'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, 0, 0);
        runCmd(7'd2, 5'd9, 1'b1, 64'd2, 64'h105, '0, 0, 0);
        checkOutput("add_wrap_model", model_acc[1], 64'd1);
        for (int i = 0; i < NUM_ACC; i++) runCmd(7'd1, 5'(i + 10), 1'b1, '0, 64'(i), '0, 0, 0);

        $display("[TB] load-add idx0");
        runCmd(7'd0, 5'd1, 1'b0, 64'd5, 64'd0, '0, 0, 0);
        runCmd(7'd3, 5'd2, 1'b1, 64'h8000_0040, 64'd0, 64'd10, 3, 0);
        checkOutput("load_add_model", model_acc[0], 64'd15);

        $display("[TB] response backpressure");
        runCmd(7'd2, 5'd11, 1'b1, 64'h77, 64'd3, '0, 0, 4);

        $display("[TB] illegal funct");
        runCmd(7'd9, 5'd12, 1'b1, 64'hABCD, 64'd2, '0, 0, 1);
        runCmd(7'd9, 5'd13, 1'b0, 64'hABCD, 64'd2, '0, 0, 0);
        runCmd(7'd1, 5'd14, 1'b1, '0, 64'd2, '0, 0, 0);

        $display("[TB] random commands");
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            f    = (kind == 4) ? 7'($urandom_range(4, 127)) : 7'(kind);
            rs1  = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            runCmd(f, 5'($urandom), 1'($urandom), rs1, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] reset during MEM_WAIT");
        applyStimulus(7'd3, 5'd7, 1'b1, 64'h1000, 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        checkOutput("mem_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) model_acc[i] = '0;
        checkIdle("midop_reset");
        checkOutput("midop_reset_resp_rd", 64'(resp_rd), 64'd0);
        checkOutput("midop_reset_resp_data", resp_data, 64'd0);
        checkOutput("midop_reset_interrupt", 64'(interrupt), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 7'd0;
        mem_resp_data  = 64'd123;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        checkIdle("stray_mem_resp");
        for (int i = 0; i < NUM_ACC; i++) runCmd(7'd1, 5'(i + 20), 1'b1, '0, 64'(i), '0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
